// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the FSM state enum and index/legend utilities.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE_DB
  } state_t;

  function automatic logic [3:0] keymap_4x4(input logic [3:0] idx);
    logic [3:0] leg;
    case (idx)
      4'd0:    leg = 4'h1;
      4'd1:    leg = 4'h2;
      4'd2:    leg = 4'h3;
      4'd3:    leg = 4'hA;
      4'd4:    leg = 4'h4;
      4'd5:    leg = 4'h5;
      4'd6:    leg = 4'h6;
      4'd7:    leg = 4'hB;
      4'd8:    leg = 4'h7;
      4'd9:    leg = 4'h8;
      4'd10:   leg = 4'h9;
      4'd11:   leg = 4'hC;
      4'd12:   leg = 4'hF;
      4'd13:   leg = 4'h0;
      4'd14:   leg = 4'hE;
      default: leg = 4'hD;
    endcase
    return leg;
  endfunction

  // Unused upper bits must be padded with ones by the caller.
  function automatic logic [2:0] onecold_to_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous column inputs.
// Resets to all ones so an idle keypad is seen out of reset.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller with debounce,
// auto-repeat and release events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CYC  = 100,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000,
  localparam int KW = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_repeat,
  output logic            key_held,
  output logic            key_release
);

  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC+1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int PW = $clog2(RMAX+1);

  if (ROWS < 2 || ROWS > 8) begin : g_bad_rows
    $error("keypad_scanner: ROWS out of range 2..8");
  end
  if (COLS < 2 || COLS > 8) begin : g_bad_cols
    $error("keypad_scanner: COLS out of range 2..8");
  end
  if (SCAN_DIV < 4) begin : g_bad_div
    $error("keypad_scanner: SCAN_DIV below 4");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("keypad_scanner: DEBOUNCE_CYC below 1");
  end

  logic [COLS-1:0] w_col;
  logic [7:0]      w_pad;
  logic            w_idle;
  logic            w_one;
  logic            w_match;
  logic            w_rep_hit;

  state_t          r_state, w_state;
  logic [RW-1:0]   r_row, w_row, w_row_inc;
  logic [SW-1:0]   r_dwell, w_dwell;
  logic [DW-1:0]   r_cnt, w_cnt;
  logic [PW-1:0]   r_rep, w_rep, w_rep_inc;
  logic            r_first, w_first;
  logic [COLS-1:0] r_pat, w_pat;
  logic [ROWS-1:0] r_row_n;
  logic [KW-1:0]   r_code, w_code;
  logic            r_valid, w_valid;
  logic            r_repeat, w_repeat;
  logic            r_release, w_release;
  logic            r_held;

  keypad_sync #(.W(COLS)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (col_n),
    .o_q (w_col)
  );

  always_comb begin
    w_pad = '1;
    w_pad[COLS-1:0] = r_pat;
  end

  assign w_idle    = &w_col;
  assign w_one     = ($countones(~w_col) == 1);
  assign w_match   = (w_col == r_pat);
  assign w_row_inc = (r_row == RW'(ROWS-1)) ? '0 : r_row + RW'(1);
  assign w_rep_inc = (r_rep == '1) ? r_rep : r_rep + PW'(1);
  assign w_rep_hit = (REPEAT_EN != 0) &&
                     (r_first ? (r_rep >= PW'(REPEAT_DELAY-1))
                              : (r_rep >= PW'(REPEAT_PERIOD-1)));

  always_comb begin
    w_state   = r_state;
    w_row     = r_row;
    w_dwell   = r_dwell;
    w_cnt     = r_cnt;
    w_rep     = r_rep;
    w_first   = r_first;
    w_pat     = r_pat;
    w_code    = r_code;
    w_valid   = 1'b0;
    w_repeat  = 1'b0;
    w_release = 1'b0;
    if (!en) begin
      w_state = S_SCAN;
      w_row   = '0;
      w_dwell = '0;
      w_cnt   = '0;
      w_rep   = '0;
      w_first = 1'b1;
    end else begin
      unique case (r_state)
        S_SCAN: begin
          if (r_dwell == SW'(SCAN_DIV-1)) begin
            w_dwell = '0;
            if (w_one) begin
              w_pat   = w_col;
              w_cnt   = '0;
              w_state = S_DEBOUNCE;
            end else begin
              w_row = w_row_inc;
            end
          end else begin
            w_dwell = r_dwell + SW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (!w_match) begin
            w_state = S_SCAN;
            w_dwell = '0;
            w_cnt   = '0;
          end else if (r_cnt == DW'(DEBOUNCE_CYC-1)) begin
            w_state = S_PRESSED;
            w_valid = 1'b1;
            w_code  = KW'(int'(r_row)*COLS +
                          int'(onecold_to_idx(w_pad)));
            w_cnt   = '0;
            w_rep   = '0;
            w_first = 1'b1;
          end else begin
            w_cnt = r_cnt + DW'(1);
          end
        end
        S_PRESSED: begin
          w_rep = w_rep_inc;
          if (!w_match) begin
            w_state = S_RELEASE_DB;
            w_cnt   = '0;
          end else if (w_rep_hit) begin
            w_valid  = 1'b1;
            w_repeat = 1'b1;
            w_rep    = '0;
            w_first  = 1'b0;
          end
        end
        S_RELEASE_DB: begin
          // Repeat timing keeps running across a release glitch.
          w_rep = w_rep_inc;
          if (w_idle) begin
            if (r_cnt == DW'(DEBOUNCE_CYC-1)) begin
              w_release = 1'b1;
              w_state   = S_SCAN;
              w_row     = w_row_inc;
              w_dwell   = '0;
              w_cnt     = '0;
            end else begin
              w_cnt = r_cnt + DW'(1);
            end
          end else if (w_match) begin
            w_state = S_PRESSED;
            w_cnt   = '0;
          end else begin
            w_cnt = '0;
          end
        end
        default: w_state = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_SCAN;
      r_row     <= '0;
      r_dwell   <= '0;
      r_cnt     <= '0;
      r_rep     <= '0;
      r_first   <= 1'b1;
      r_pat     <= '1;
      r_row_n   <= ~ROWS'(1);
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_row     <= w_row;
      r_dwell   <= w_dwell;
      r_cnt     <= w_cnt;
      r_rep     <= w_rep;
      r_first   <= w_first;
      r_pat     <= w_pat;
      r_row_n   <= en ? ~(ROWS'(1) << w_row) : '1;
      r_code    <= w_code;
      r_valid   <= w_valid;
      r_repeat  <= w_repeat;
      r_release <= w_release;
      r_held    <= (w_state == S_PRESSED) ||
                   (w_state == S_RELEASE_DB);
    end
  end

  assign row_n       = r_row_n;
  assign key_code    = r_code;
  assign key_valid   = r_valid;
  assign key_repeat  = r_repeat;
  assign key_held    = r_held;
  assign key_release = r_release;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner on a 4x4 matrix model.
// Expected events are queued at stimulus time, popped on output.
module tb_keypad_scanner;

  localparam int DEB = 8;

  typedef struct {
    int kind;
    int code;
    int at;
    int gap;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_repeat;
  logic       key_held;
  logic       key_release;

  int   n_chk;
  int   n_fail;
  int   cyc;
  int   last_ev;
  ev_t  sb[$];
  logic key_down;
  logic ghost;
  int   kr;
  int   kc;

  keypad_scanner #(
    .ROWS          (4),
    .COLS          (4),
    .SCAN_DIV      (4),
    .DEBOUNCE_CYC  (DEB),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (50),
    .REPEAT_PERIOD (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .col_n       (col_n),
    .row_n       (row_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_held    (key_held),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a closed switch shorts its row to its column.
  always_comb begin
    col_n = 4'hF;
    if (ghost && !row_n[1]) col_n = 4'b1001;
    else if (key_down && !row_n[kr]) col_n = ~(4'b0001 << kc);
  end

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (key_valid || key_release)) begin
      ev_t e;
      int  kind;
      check_eq("valid_release_excl",
               32'(key_valid & key_release), 0);
      kind = key_release ? 2 : (key_repeat ? 1 : 0);
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_eq("ev_kind", kind, e.kind);
        check_eq("ev_held", 32'(key_held), (kind == 2) ? 0 : 1);
        if (kind != 2) check_eq("ev_code", 32'(key_code), e.code);
        if (e.at >= 0) check_eq("ev_cycle", cyc, e.at);
        if (e.gap >= 0) check_eq("ev_gap", cyc - last_ev, e.gap);
      end
      last_ev = cyc;
    end
  end

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({"drain_", tag}, sb.size(), 0);
  endtask

  task automatic push_press(input int r, input int c);
    sb.push_back('{0, r*4 + c, -1, -1});
    kr = r;
    kc = c;
    key_down = 1'b1;
  endtask

  task automatic push_release();
    sb.push_back('{2, 0, cyc + DEB + 3, -1});
    key_down = 1'b0;
  endtask

  initial begin
    int         tab_r[3];
    int         tab_c[3];
    logic [3:0] exp_row;
    logic [3:0] seen;
    int         p;
    int         k;

    tab_r = '{2, 3, 0};
    tab_c = '{1, 0, 3};
    n_chk = 0; n_fail = 0; cyc = 0; last_ev = 0;
    rst = 1'b1; en = 1'b1;
    key_down = 1'b0; ghost = 1'b0; kr = 0; kc = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_row_n", 32'(row_n), 4'b1110);
    check_eq("rst_code", 32'(key_code), 0);
    check_eq("rst_valid", 32'(key_valid), 0);
    check_eq("rst_held", 32'(key_held), 0);
    check_eq("rst_release", 32'(key_release), 0);
    rst = 1'b0;

    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((m / 4) % 4));
      check_eq($sformatf("idle_row%0d", m), 32'(row_n), exp_row);
    end

    for (int i = 0; i < 3; i++) begin
      push_press(tab_r[i], tab_c[i]);
      drain($sformatf("press%0d", i), 200);
      repeat (10) @(negedge clk);
      push_release();
      drain($sformatf("rel%0d", i), 50);
      check_eq($sformatf("code_hold%0d", i), 32'(key_code),
               tab_r[i]*4 + tab_c[i]);
      repeat (7) @(negedge clk);
    end

    kr = 1; kc = 2;
    for (int i = 0; i < 40; i++) begin
      key_down = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    push_press(1, 2);
    drain("bounce_press", 200);
    repeat (5) @(negedge clk);
    push_release();
    drain("bounce_rel", 50);

    ghost = 1'b1;
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= ~row_n;
    end
    ghost = 1'b0;
    check_eq("ghost_rows", 32'(seen), 4'hF);
    check_eq("ghost_held", 32'(key_held), 0);

    sb.push_back('{0, 15, -1, -1});
    sb.push_back('{1, 15, -1, 50});
    sb.push_back('{1, 15, -1, 20});
    sb.push_back('{1, 15, -1, 20});
    sb.push_back('{1, 15, -1, 20});
    kr = 3; kc = 3; key_down = 1'b1;
    k = 0;
    while (sb.size() > 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("rep_press_seen", sb.size(), 4);
    p = last_ev;
    k = 0;
    while (cyc < p + 112 && k < 200) begin
      @(negedge clk);
      k++;
    end
    push_release();
    drain("repeat", 60);

    push_press(1, 1);
    drain("rst_press", 200);
    @(negedge clk);
    rst = 1'b1;
    key_down = 1'b0;
    #1;
    check_eq("midrst_row_n", 32'(row_n), 4'b1110);
    check_eq("midrst_code", 32'(key_code), 0);
    check_eq("midrst_held", 32'(key_held), 0);
    check_eq("midrst_valid", 32'(key_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    push_press(2, 3);
    drain("en_press", 200);
    en = 1'b0;
    @(negedge clk);
    check_eq("dis_row_n", 32'(row_n), 4'hF);
    check_eq("dis_held", 32'(key_held), 0);
    check_eq("dis_code", 32'(key_code), 11);
    check_eq("dis_valid", 32'(key_valid), 0);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("dis_release", 32'(key_release), 0);
    en = 1'b1;
    @(negedge clk);
    check_eq("reen_row0", 32'(row_n), 4'b1110);
    repeat (3) @(negedge clk);
    check_eq("reen_row1", 32'(row_n), 4'b1101);
    repeat (20) @(negedge clk);

    check_eq("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
